fnd_scan_ctrl: RTL and testbench

FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

---
 rtl/fnd_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: accepts a 14-bit binary value, converts it to four BCD digits
// with a serial shift-add-3 engine, and time-multiplexes the digits onto a
// 4-digit FND (seven-segment) display through a BCD digit bus.
//
// Parameters:
//   SCAN_DIV     clock cycles per digit slot (2..2^20)
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_value      unsigned binary value to display (saturated to 9999)
//   i_valid      i_value offered for loading
//   o_ready      block accepts a value this cycle (IDLE only)
//   o_ovf        last accepted value exceeded 9999
//   o_fndSel     active-low one-hot digit enable, bit0 = ones digit
//   o_fndData    BCD digit for the enabled position
// Build option:
//   LEADING_ZERO_BLANK_EN  blank leading-zero slots (o_fndSel = 4'b1111);
//                          the ones digit is never blanked.
module fnd_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [13:0] i_value,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_ovf,
  output logic [3:0]  o_fndSel,
  output logic [3:0]  o_fndData
);

  localparam int unsigned VAL_W   = 14;
  localparam int unsigned BCD_W   = 16;
  localparam int unsigned SHIFT_W = VAL_W + BCD_W;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [VAL_W-1:0] MAX_VAL   = VAL_W'(9999);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(VAL_W - 1);
  localparam logic [CNT_W-1:0] TERM_CNT  = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } stateType;

  stateType         state, stateNext;
  logic [VAL_W-1:0] binReg, binNext;
  logic [BCD_W-1:0] bcdReg, bcdNext;
  logic [BIT_W-1:0] bitCnt, bitCntNext;
  logic [BCD_W-1:0] dispReg, dispNext;
  logic             ovfNext;
  logic             readyNext;

  logic [CNT_W-1:0] scanCnt;
  logic [1:0]       scanIdx;
  logic             scanTick_c;
  logic [3:0]       curDigit_c;
  logic             blank_c;

  // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
  function automatic logic [BCD_W-1:0] addThree(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int d = 0; d < 4; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) begin
        res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  // Conversion FSM state and datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      binReg  <= '0;
      bcdReg  <= '0;
      bitCnt  <= '0;
      dispReg <= '0;
      o_ovf   <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      state   <= stateNext;
      binReg  <= binNext;
      bcdReg  <= bcdNext;
      bitCnt  <= bitCntNext;
      dispReg <= dispNext;
      o_ovf   <= ovfNext;
      o_ready <= readyNext;
    end
  end

  // Next-state and datapath logic for accept / convert / commit.
  always_comb begin
    logic [SHIFT_W-1:0] shifted;
    stateNext  = state;
    binNext    = binReg;
    bcdNext    = bcdReg;
    bitCntNext = bitCnt;
    dispNext   = dispReg;
    ovfNext    = o_ovf;
    shifted    = '0;

    case (state)
      IDLE: begin
        if (i_valid && o_ready) begin
          binNext    = (i_value > MAX_VAL) ? MAX_VAL : i_value;
          ovfNext    = (i_value > MAX_VAL);
          bcdNext    = '0;
          bitCntNext = '0;
          stateNext  = CONV;
        end
      end
      CONV: begin
        shifted    = {addThree(bcdReg), binReg} << 1;
        bcdNext    = shifted[SHIFT_W-1:VAL_W];
        binNext    = shifted[VAL_W-1:0];
        bitCntNext = bitCnt + BIT_W'(1);
        if (bitCnt == LAST_BIT) begin
          stateNext = COMMIT;
        end
      end
      COMMIT: begin
        dispNext  = bcdReg;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // Registered ready mirrors "next state is IDLE".
    readyNext = (stateNext == IDLE);
  end

  // Prescaler and digit index, free-running independent of the FSM.
  assign scanTick_c = (scanCnt == TERM_CNT);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      scanCnt <= '0;
      scanIdx <= '0;
    end else if (scanTick_c) begin
      scanCnt <= '0;
      scanIdx <= scanIdx + 2'd1;
    end else begin
      scanCnt <= scanCnt + CNT_W'(1);
    end
  end

  // Digit selected by the current index.
  assign curDigit_c = dispReg[{scanIdx, 2'b00} +: 4];

  // Leading-zero detection: slot blanked when it and all higher digits are 0.
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank_c = 1'b0;
    case (scanIdx)
      2'd1:    blank_c = (dispReg[15:4]  == '0);
      2'd2:    blank_c = (dispReg[15:8]  == '0);
      2'd3:    blank_c = (dispReg[15:12] == '0);
      default: blank_c = 1'b0;
    endcase
  end
`else
  assign blank_c = 1'b0;
`endif

  // Registered display drive.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_fndSel  <= 4'b1110;
      o_fndData <= 4'd0;
    end else begin
      o_fndSel  <= blank_c ? 4'b1111 : ~(4'b0001 << scanIdx);
      o_fndData <= curDigit_c;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed self-checking bench for fnd_scan_ctrl with SCAN_DIV = 4.
module tb_fnd_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [13:0] value;
  logic        valid;
  logic        ready;
  logic        ovf;
  logic [3:0]  fndSel;
  logic [3:0]  fndData;

  int errors = 0;
  int checks = 0;

  fnd_scan_ctrl #(.SCAN_DIV(4)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_value   (value),
    .i_valid   (valid),
    .o_ready   (ready),
    .o_ovf     (ovf),
    .o_fndSel  (fndSel),
    .o_fndData (fndData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a value for one edge; returns after the accepting edge.
  task automatic load(input logic [13:0] v, input string tag);
    @(negedge clk);
    value = v;
    valid = 1'b1;
    step();
    valid = 1'b0;
    chk({tag, " ready low after accept"}, 16'(ready), 16'd0);
  endtask

  task automatic waitReady(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk({tag, " ready returns"}, 16'(found), 16'd1);
  endtask

  // Wait (bounded) for a slot enable pattern, then check its digit.
  task automatic waitSel(input logic [3:0] sel, input logic [3:0] expData, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (fndSel === sel) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, " slot seen"}, 16'(found), 16'd1);
    chk({tag, " digit"}, 16'(fndData), 16'(expData));
  endtask

  task automatic checkSlots(input logic [15:0] bcd, input string tag);
    waitSel(4'b1110, bcd[3:0],   {tag, " d0"});
    waitSel(4'b1101, bcd[7:4],   {tag, " d1"});
    waitSel(4'b1011, bcd[11:8],  {tag, " d2"});
    waitSel(4'b0111, bcd[15:12], {tag, " d3"});
  endtask

  logic [3:0] selSeq [4];
  logic [15:0] bcd1234;
  int nBlank;
  int nOnes;
  int slot;

  initial begin
    selSeq[0] = 4'b1110;
    selSeq[1] = 4'b1101;
    selSeq[2] = 4'b1011;
    selSeq[3] = 4'b0111;
    bcd1234   = 16'h1234;

    rst   = 1'b1;
    value = '0;
    valid = 1'b0;
    #1;
    chk("reset sel",  16'(fndSel),  16'hE);
    chk("reset data", 16'(fndData), 16'd0);
    chk("reset ovf",  16'(ovf),     16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("ready after reset", 16'(ready), 16'd1);

    // Scan rotation from reset: each enable held for 4 edges.
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("scan sel edge %0d", k), 16'(fndSel), 16'(selSeq[(k-1)/4]));
      chk($sformatf("scan data edge %0d", k), 16'(fndData), 16'd0);
    end

    // 1234: ready low through conversion and commit, digits land 16 edges after accept.
    load(14'd1234, "1234");
    for (int k = 1; k <= 14; k++) begin
      step();
      chk($sformatf("1234 ready low edge %0d", k), 16'(ready), 16'd0);
    end
    step();
    chk("1234 ready high edge 15", 16'(ready), 16'd1);
    chk("1234 old digit at edge 15", 16'(fndData), 16'd0);
    step();
    slot = (fndSel == 4'b1110) ? 0 : (fndSel == 4'b1101) ? 1 : (fndSel == 4'b1011) ? 2 : 3;
    chk("1234 new digit at edge 16", 16'(fndData), 16'(bcd1234[4*slot +: 4]));
    chk("1234 ovf", 16'(ovf), 16'd0);
    checkSlots(16'h1234, "1234");

    // Saturation: 16383 and the first overflowing value.
    load(14'd16383, "16383");
    waitReady("16383");
    chk("16383 ovf", 16'(ovf), 16'd1);
    checkSlots(16'h9999, "16383");

    load(14'd10000, "10000");
    waitReady("10000");
    chk("10000 ovf", 16'(ovf), 16'd1);
    checkSlots(16'h9999, "10000");

    load(14'd9999, "9999");
    waitReady("9999");
    chk("9999 ovf", 16'(ovf), 16'd0);
    checkSlots(16'h9999, "9999");

    // 5678 with an ignored offer of 42 on edge 5 of the conversion.
    load(14'd5678, "5678");
    repeat (4) step();
    @(negedge clk);
    value = 14'd42;
    valid = 1'b1;
    step();
    valid = 1'b0;
    chk("5678 ready low at edge 5", 16'(ready), 16'd0);
    waitReady("5678");
    chk("5678 ovf", 16'(ovf), 16'd0);
    checkSlots(16'h5678, "5678");

    // Reset at edge 8 of converting 777: outputs reset at once, 777 never shown.
    load(14'd777, "777");
    repeat (8) step();
    #2;
    rst = 1'b1;
    #1;
    chk("abort sel",  16'(fndSel),  16'hE);
    chk("abort data", 16'(fndData), 16'd0);
    chk("abort ovf",  16'(ovf),     16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      chk($sformatf("abort data edge %0d", k), 16'(fndData), 16'd0);
    end
    chk("abort ready", 16'(ready), 16'd1);

`ifdef LEADING_ZERO_BLANK_EN
    load(14'd7, "blank7");
    waitReady("blank7");
    waitSel(4'b1110, 4'd7, "blank7 d0");
    nBlank = 0;
    nOnes  = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (fndSel === 4'b1111) nBlank++;
      if (fndSel === 4'b1110) nOnes++;
    end
    chk("blank7 blanked edges", 16'(nBlank), 16'd12);
    chk("blank7 ones edges",    16'(nOnes),  16'd4);
    load(14'd0, "blank0");
    waitReady("blank0");
    waitSel(4'b1110, 4'd0, "blank0 d0");
`else
    load(14'd7, "zero7");
    waitReady("zero7");
    checkSlots(16'h0007, "zero7");
    nBlank = 0;
    nOnes  = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (fndSel === 4'b1111) nBlank++;
    end
    chk("zero7 no blanking", 16'(nBlank), 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
